// File: rtl/key_debounce.sv
// Per-key push-button conditioning: 2-flop synchronizer, optional counter-based debounce FSM,
// active-high level output and registered one-cycle press/release strobes.
module key_debounce #(
  parameter int unsigned N_KEYS        = 5,
  parameter int unsigned STABLE_CYCLES = 1000000,
  parameter int unsigned CNT_WIDTH     = 20
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              db_en,
  input  logic [N_KEYS-1:0] btn_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StPressed,
    StReleaseWait
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(STABLE_CYCLES - 1);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    logic                 s1_q, s2_q, p;
    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 level_q, level_d;
    logic                 press_q, press_d;
    logic                 release_q, release_d;

    assign p = ~s2_q;

    always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
        s1_q      <= 1'b1;
        s2_q      <= 1'b1;
        state_q   <= StIdle;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        s1_q      <= btn_n[i];
        s2_q      <= s1_q;
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      if (!db_en) begin
        // Bypass parks the FSM in the stable state matching the level, so re-enabling resumes cleanly.
        state_d = p ? StPressed : StIdle;
        cnt_d   = '0;
        level_d = p;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (p) begin
              state_d = StPressWait;
              cnt_d   = '0;
            end
          end
          StPressWait: begin
            if (!p) begin
              state_d = StIdle;
              cnt_d   = '0;
            end else if (cnt_q == CntMax) begin
              state_d = StPressed;
              cnt_d   = '0;
              level_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_WIDTH'(1);
            end
          end
          StPressed: begin
            if (!p) begin
              state_d = StReleaseWait;
              cnt_d   = '0;
            end
          end
          StReleaseWait: begin
            if (p) begin
              state_d = StPressed;
              cnt_d   = '0;
            end else if (cnt_q == CntMax) begin
              state_d = StIdle;
              cnt_d   = '0;
              level_d = 1'b0;
            end else begin
              cnt_d = cnt_q + CNT_WIDTH'(1);
            end
          end
          default: begin
            state_d = StIdle;
            cnt_d   = '0;
            level_d = 1'b0;
          end
        endcase
      end
    end

    // Strobes derive from the level change, so press and release can never coincide.
    assign press_d   = level_d & ~level_q;
    assign release_d = ~level_d & level_q;

    assign key_level[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with STABLE_CYCLES = 4: vector table plus hand-written
// sequences for bounce, glitch and reset-during-qualification.
module tb_key_debounce;

  logic       clk_50m = 1'b0;
  logic       rst_n   = 1'b0;
  logic       db_en   = 1'b1;
  logic [4:0] btn_n   = 5'b11111;
  logic [4:0] key_level, key_press, key_release;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       rst_n;
    logic       db_en;
    logic [4:0] btn_n;
    logic [4:0] lvl;
    logic [4:0] prs;
    logic [4:0] rel;
  } vec_t;

  vec_t vecs[$];

  always #10 clk_50m = ~clk_50m;

  key_debounce #(
    .N_KEYS       (5),
    .STABLE_CYCLES(4),
    .CNT_WIDTH    (3)
  ) dut (
    .clk_50m    (clk_50m),
    .rst_n      (rst_n),
    .db_en      (db_en),
    .btn_n      (btn_n),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release)
  );

  function automatic void add(input logic r, input logic en, input logic [4:0] b, input int n,
                              input logic [4:0] l, input logic [4:0] p, input logic [4:0] rl);
    vec_t v;
    v.rst_n = r;
    v.db_en = en;
    v.btn_n = b;
    v.lvl   = l;
    v.prs   = p;
    v.rel   = rl;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [4:0] l, input logic [4:0] p,
                       input logic [4:0] rl);
    checks++;
    if ({key_level, key_press, key_release} !== {l, p, rl}) begin
      failures++;
      $display("FAIL %s: got level=%b press=%b release=%b, expected level=%b press=%b release=%b",
               name, key_level, key_press, key_release, l, p, rl);
    end
  endtask

  task automatic step();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic expect_run(input string name, input int n, input logic [4:0] l,
                            input logic [4:0] p, input logic [4:0] rl);
    for (int i = 0; i < n; i++) begin
      step();
      check($sformatf("%s[%0d]", name, i), l, p, rl);
    end
  endtask

  initial begin
    // Reset state and idle
    #5;
    check("reset_async", 5'b0, 5'b0, 5'b0);
    repeat (3) step();
    check("reset_hold", 5'b0, 5'b0, 5'b0);
    rst_n = 1'b1;
    expect_run("idle", 20, 5'b0, 5'b0, 5'b0);

    // Clean press/release on key 0: level changes 6 edges after the first sampling edge
    add(1, 1, 5'b11110, 6, 5'b00000, 5'b00000, 5'b00000);
    add(1, 1, 5'b11110, 1, 5'b00001, 5'b00001, 5'b00000);
    add(1, 1, 5'b11110, 3, 5'b00001, 5'b00000, 5'b00000);
    add(1, 1, 5'b11111, 6, 5'b00001, 5'b00000, 5'b00000);
    add(1, 1, 5'b11111, 1, 5'b00000, 5'b00000, 5'b00001);
    add(1, 1, 5'b11111, 2, 5'b00000, 5'b00000, 5'b00000);
    // Bypass on key 4: two-edge latency
    add(1, 0, 5'b01111, 2, 5'b00000, 5'b00000, 5'b00000);
    add(1, 0, 5'b01111, 1, 5'b10000, 5'b10000, 5'b00000);
    add(1, 0, 5'b01111, 2, 5'b10000, 5'b00000, 5'b00000);
    add(1, 0, 5'b11111, 2, 5'b10000, 5'b00000, 5'b00000);
    add(1, 0, 5'b11111, 1, 5'b00000, 5'b00000, 5'b10000);
    add(1, 0, 5'b11111, 2, 5'b00000, 5'b00000, 5'b00000);
    // Key 3: bypass enabled mid-PRESS_WAIT collapses to pressed, then debounced release
    add(1, 1, 5'b10111, 4, 5'b00000, 5'b00000, 5'b00000);
    add(1, 0, 5'b10111, 1, 5'b01000, 5'b01000, 5'b00000);
    add(1, 0, 5'b10111, 1, 5'b01000, 5'b00000, 5'b00000);
    add(1, 1, 5'b10111, 2, 5'b01000, 5'b00000, 5'b00000);
    add(1, 1, 5'b11111, 6, 5'b01000, 5'b00000, 5'b00000);
    add(1, 1, 5'b11111, 1, 5'b00000, 5'b00000, 5'b01000);
    add(1, 1, 5'b11111, 2, 5'b00000, 5'b00000, 5'b00000);

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n;
      db_en = vecs[i].db_en;
      btn_n = vecs[i].btn_n;
      step();
      check($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].prs, vecs[i].rel);
    end

    // Bounce on key 1: no strobe during toggling, one press 6 edges after the final low
    db_en = 1'b1;
    for (int t = 0; t < 2; t++) begin
      btn_n = 5'b11101;
      expect_run("bounce_lo", 2, 5'b0, 5'b0, 5'b0);
      btn_n = 5'b11111;
      expect_run("bounce_hi", 2, 5'b0, 5'b0, 5'b0);
    end
    btn_n = 5'b11101;
    expect_run("bounce_settle", 6, 5'b0, 5'b0, 5'b0);
    expect_run("bounce_press", 1, 5'b00010, 5'b00010, 5'b0);
    expect_run("bounce_held", 2, 5'b00010, 5'b0, 5'b0);
    btn_n = 5'b11111;
    expect_run("bounce_relwait", 6, 5'b00010, 5'b0, 5'b0);
    expect_run("bounce_release", 1, 5'b0, 5'b0, 5'b00010);
    expect_run("bounce_done", 1, 5'b0, 5'b0, 5'b0);

    // Glitch on key 2 shorter than STABLE_CYCLES
    btn_n = 5'b11011;
    expect_run("glitch_lo", 3, 5'b0, 5'b0, 5'b0);
    btn_n = 5'b11111;
    expect_run("glitch_after", 7, 5'b0, 5'b0, 5'b0);

    // Keys 0 and 3 together, reset at count 2, re-qualified after reset
    btn_n = 5'b10110;
    expect_run("mk_wait", 5, 5'b0, 5'b0, 5'b0);
    rst_n = 1'b0;
    #1;
    check("mk_reset_async", 5'b0, 5'b0, 5'b0);
    expect_run("mk_reset_hold", 2, 5'b0, 5'b0, 5'b0);
    rst_n = 1'b1;
    expect_run("mk_requal", 6, 5'b0, 5'b0, 5'b0);
    expect_run("mk_press", 1, 5'b01001, 5'b01001, 5'b0);
    expect_run("mk_held", 1, 5'b01001, 5'b0, 5'b0);
    btn_n = 5'b11111;
    expect_run("mk_relwait", 6, 5'b01001, 5'b0, 5'b0);
    expect_run("mk_release", 1, 5'b0, 5'b0, 5'b01001);
    expect_run("mk_done", 1, 5'b0, 5'b0, 5'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
